// File: rtl/shift_ser_out_if.sv
// shift_ser_out_if: start/done handshake plus serial pins of the parallel-to-serial transmitter
// master: drives i_start/i_data, observes o_ser/o_serclk/o_latch/o_busy/o_done
// slave : the transmitter side
interface shift_ser_out_if #(parameter int WIDTH = 16);
  logic             i_start;
  logic [WIDTH-1:0] i_data;
  logic             o_ser;
  logic             o_serclk;
  logic             o_latch;
  logic             o_busy;
  logic             o_done;
  modport master (output i_start, i_data, input o_ser, o_serclk, o_latch, o_busy, o_done);
  modport slave (input i_start, i_data, output o_ser, o_serclk, o_latch, o_busy, o_done);
endinterface

// File: rtl/shift_ser_out.sv
// shift_ser_out: shifts a WIDTH-bit word MSB first into a 595-style chain, then strobes its latch
// clk   : rising-edge system clock
// reset : synchronous active-high reset
// bus   : shift_ser_out_if slave (i_start/i_data in; o_ser/o_serclk/o_latch/o_busy/o_done out)
module shift_ser_out #(
  parameter int WIDTH     = 16,
  parameter int SCLK_HALF = 1
) (
  input logic          clk,
  input logic          reset,
  shift_ser_out_if.slave bus
);
  localparam int HW = $clog2(SCLK_HALF + 1);
  localparam int BW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LATCH, DONE} state_t;
  state_t           state, nxt;
  logic [HW-1:0]    hcnt, hcnt_nxt;
  logic [BW-1:0]    bcnt, bcnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             ser_nxt, serclk_nxt, latch_nxt, busy_nxt, done_nxt;
  logic             last;
  assign last = hcnt == HW'(SCLK_HALF - 1);
  always_ff @(posedge clk)
    if (reset) begin
      state        <= IDLE;
      hcnt         <= '0;
      bcnt         <= '0;
      shreg        <= '0;
      bus.o_ser    <= 1'b0;
      bus.o_serclk <= 1'b0;
      bus.o_latch  <= 1'b0;
      bus.o_busy   <= 1'b0;
      bus.o_done   <= 1'b0;
    end else begin
      state        <= nxt;
      hcnt         <= hcnt_nxt;
      bcnt         <= bcnt_nxt;
      shreg        <= shreg_nxt;
      bus.o_ser    <= ser_nxt;
      bus.o_serclk <= serclk_nxt;
      bus.o_latch  <= latch_nxt;
      bus.o_busy   <= busy_nxt;
      bus.o_done   <= done_nxt;
    end
  always_comb begin
    nxt       = state;
    shreg_nxt = shreg;
    bcnt_nxt  = bcnt;
    case (state)
      IDLE:
        if (bus.i_start) begin
          nxt       = SETUP;
          shreg_nxt = bus.i_data;
          bcnt_nxt  = BW'(WIDTH);
        end
      SETUP: if (last) nxt = HIGH;
      HIGH:
        if (last) begin
          nxt       = bcnt == BW'(1) ? LATCH : SETUP;
          shreg_nxt = shreg << 1;
          bcnt_nxt  = bcnt - 1'b1;
        end
      LATCH: if (last) nxt = DONE;
      default: nxt = IDLE;
    endcase
    hcnt_nxt = (nxt != state || state == IDLE) ? '0 : hcnt + 1'b1;
  end
  // outputs are decoded from the upcoming state so they register together with it
  always_comb begin
    serclk_nxt = nxt == HIGH;
    latch_nxt  = nxt == LATCH;
    busy_nxt   = nxt != IDLE;
    done_nxt   = nxt == DONE;
    ser_nxt    = nxt == IDLE ? 1'b0 : nxt == SETUP ? shreg_nxt[WIDTH-1] : bus.o_ser;
  end
endmodule

// File: tb/tb_shift_ser_out.sv
// tb_shift_ser_out: random and directed transfers checked against a 595-chain model
module tb_shift_ser_out;
  localparam int DONE0 = 1 + 2 * 1 * 16 + 1;
  localparam int DONE1 = 1 + 2 * 3 * 8 + 3;
  logic clk = 1'b0;
  logic r0, r1;
  int total = 0;
  int bad = 0;
  shift_ser_out_if #(.WIDTH(16)) i0 ();
  shift_ser_out_if #(.WIDTH(8)) i1 ();
  shift_ser_out #(.WIDTH(16), .SCLK_HALF(1)) u0 (.clk(clk), .reset(r0), .bus(i0));
  shift_ser_out #(.WIDTH(8), .SCLK_HALF(3)) u1 (.clk(clk), .reset(r1), .bus(i1));
  always #5 clk = ~clk;
  logic [15:0] sr0, q0;
  logic [7:0]  sr1, q1;
  int sc0 = 0, lc0 = 0, dn0 = 0, sc1 = 0, lc1 = 0, dn1 = 0;
  always @(posedge i0.o_serclk) begin
    sr0 <= {sr0[14:0], i0.o_ser};
    sc0 <= sc0 + 1;
  end
  always @(posedge i0.o_latch) begin
    q0  <= sr0;
    lc0 <= lc0 + 1;
  end
  always @(posedge i1.o_serclk) begin
    sr1 <= {sr1[6:0], i1.o_ser};
    sc1 <= sc1 + 1;
  end
  always @(posedge i1.o_latch) begin
    q1  <= sr1;
    lc1 <= lc1 + 1;
  end
  always @(posedge clk) begin
    if (i0.o_done) dn0 <= dn0 + 1;
    if (i1.o_done) dn1 <= dn1 + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run0(input logic [15:0] d, input int inj_k, input int rst_k, input logic [15:0] exp_q);
    int s, l, n, dk;
    s = sc0; l = lc0; n = dn0; dk = 0;
    i0.i_data = d;
    i0.i_start = 1'b1;
    @(posedge clk); #1;
    i0.i_start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 1) begin
        chk("busy_first", i0.o_busy, 1);
        chk("ser_first", i0.o_ser, d[15]);
      end
      if (k == inj_k) begin
        i0.i_start = 1'b1;
        i0.i_data = 16'hffff;
      end
      if (k == inj_k + 1) i0.i_start = 1'b0;
      if (k == rst_k) r0 = 1'b1;
      if (k == rst_k + 1) begin
        r0 = 1'b0;
        chk("rst_outs", {i0.o_ser, i0.o_serclk, i0.o_latch, i0.o_busy, i0.o_done}, 0);
      end
      if (i0.o_done && dk == 0) dk = k;
      if (dk != 0 && k == dk + 1) chk("busy_end", i0.o_busy, 0);
      @(posedge clk); #1;
    end
    if (rst_k > 0) begin
      chk("rst_no_done", dn0 - n, 0);
      chk("rst_no_latch", lc0 - l, 0);
    end else begin
      chk("done_cyc", dk, DONE0);
      chk("edges", sc0 - s, 16);
      chk("latches", lc0 - l, 1);
      chk("dones", dn0 - n, 1);
    end
    chk("q_word", q0, exp_q);
  endtask
  task automatic run1(input logic [7:0] d);
    int s, l, n, dk, hi, lw;
    s = sc1; l = lc1; n = dn1; dk = 0; hi = 0; lw = 0;
    i1.i_data = d;
    i1.i_start = 1'b1;
    @(posedge clk); #1;
    i1.i_start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (i1.o_serclk) hi++;
      if (i1.o_latch) lw++;
      if (i1.o_done && dk == 0) dk = k;
      @(posedge clk); #1;
    end
    chk("w8_done_cyc", dk, DONE1);
    chk("w8_edges", sc1 - s, 8);
    chk("w8_high_cyc", hi, 24);
    chk("w8_latch_w", lw, 3);
    chk("w8_latches", lc1 - l, 1);
    chk("w8_dones", dn1 - n, 1);
    chk("w8_q", q1, d);
  endtask
  initial begin
    logic [15:0] w;
    int s, n;
    r0 = 1'b1; r1 = 1'b1;
    i0.i_start = 1'b0; i0.i_data = '0;
    i1.i_start = 1'b0; i1.i_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset0", {i0.o_ser, i0.o_serclk, i0.o_latch, i0.o_busy, i0.o_done}, 0);
    chk("reset1", {i1.o_ser, i1.o_serclk, i1.o_latch, i1.o_busy, i1.o_done}, 0);
    r0 = 1'b0; r1 = 1'b0;
    @(posedge clk); #1;
    run0(16'haa55, -5, -5, 16'haa55);
    run0(16'haa55, 10, -5, 16'haa55);
    run0(16'h00ff, -5, -5, 16'h00ff);
    run0(16'hff00, -5, 11, 16'h00ff);
    run1(8'hc3);
    repeat (6) begin
      w = 16'($urandom);
      run0(w, -5, -5, w);
    end
    repeat (3) run1(8'($urandom));
    s = sc0; n = dn0;
    i0.i_data = 16'h0000;
    i0.i_start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 72; k++) begin
      if (k == 34) begin
        chk("b2b_done1", i0.o_done, 1);
        chk("b2b_q1", q0, 16'h0000);
        i0.i_data = 16'hffff;
      end
      if (k == 35) chk("b2b_gap", i0.o_busy, 0);
      if (k == 36) begin
        chk("b2b_busy2", i0.o_busy, 1);
        chk("b2b_ser2", i0.o_ser, 1);
      end
      if (k == 69) begin
        chk("b2b_done2", i0.o_done, 1);
        chk("b2b_q2", q0, 16'hffff);
        i0.i_start = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("b2b_dones", dn0 - n, 2);
    chk("b2b_edges", sc0 - s, 32);
    chk("b2b_idle", i0.o_busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
